veerwolf_sevseg: RTL
====================

VEERWOLF_SEVSEG -- requirements
Module: veerwolf_sevseg

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of scanned digits, legal range 1..16.
REQ-002 SHALL have parameter SCAN_DIV_W, default 18, prescaler width; one digit slot lasts 2^SCAN_DIV_W clocks; minimum 4.
REQ-003 SHALL have parameter BLINK_W, default 6, blink half-period = 2^BLINK_W full scan frames.
REQ-004 SHALL have port i_clk, input, 1, the single clock; one clock, reset synchronous active-high.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have Wishbone slave ports: i_wb_adr in 5 [4:0] byte address; i_wb_dat in 32; i_wb_sel in 4; i_wb_we in 1; i_wb_cyc in 1; i_wb_stb in 1; o_wb_rdt out 32; o_wb_ack out 1.
REQ-007 SHALL have o_an, output, N_DIGITS, active-low digit anodes.
REQ-008 SHALL have o_seg, output, 7, active-low segments {a,b,c,d,e,f,g}, a in bit 6.
REQ-009 SHALL have o_dp, output, 1, active-low decimal point.

Function
REQ-010 Register map, byte-lane writes via i_wb_sel: 0x00 ENABLE[N_DIGITS-1:0]; 0x04 DIGITS_LO (digits 0-7, 4 bits each, digit 0 in [3:0]); 0x08 DIGITS_HI (digits 8-15); 0x0C DP[N_DIGITS-1:0]; 0x10 BRIGHT[3:0]; 0x14 BLINK[N_DIGITS-1:0]; other offsets read 0, writes ignored.
REQ-011 Bits beyond N_DIGITS SHALL read 0 and ignore writes; DIGITS_HI SHALL read 0 when N_DIGITS<=8.
REQ-012 o_wb_ack SHALL be asserted exactly one clock after i_wb_cyc&i_wb_stb with o_wb_ack low, and SHALL deassert the following clock (single-cycle ack, no back-to-back ack).
REQ-013 A write SHALL take effect in the cycle ack is asserted; o_wb_rdt SHALL be valid with ack.
REQ-014 Prescaler SHALL free-run; digit index SHALL advance when prescaler is all-ones and wrap from N_DIGITS-1 to 0 (non-power-of-two counts supported).
REQ-015 Frame counter (BLINK_W bits) SHALL increment on each index wrap; blink phase SHALL toggle when it overflows.
REQ-016 Selected digit's anode SHALL be asserted (0) only when ENABLE[idx]=1, top 4 prescaler bits <= BRIGHT, and not (BLINK[idx]=1 and blink phase=1); all other anodes 1.
REQ-017 BRIGHT=15 SHALL give 100% duty; BRIGHT=0 SHALL give 1/16 duty.
REQ-018 o_seg SHALL be hex decode of the selected nibble (0-F, standard 7-seg glyphs, 8 = all segments on); o_dp = ~DP[idx].
REQ-019 o_an, o_seg, o_dp SHALL be registered: one clock latency from index/prescaler to pins; all three change on the same edge (no ghosting between digits).
REQ-020 A register write mid-slot SHALL affect outputs one clock after ack, without restarting scan.

Reset
REQ-021 On i_rst: all registers, prescaler, index, frame counter, blink phase = 0; o_wb_ack=0, o_wb_rdt=0, o_an all ones, o_seg=7'b0000001, o_dp=1.
REQ-022 Reset asserted during a bus cycle SHALL suppress ack that cycle; master retries.

Configuration
REQ-023 Macro VEERWOLF_SEVSEG_BLINK_EN: defined -> BLINK register, frame counter and blink gating present; undefined -> 0x14 reads 0, writes ignored, no blanking from blink, frame logic absent.

Structure
REQ-024 Package veerwolf_sevseg_pkg SHALL hold register offset constants, 16-entry glyph table constant, and digit-count legality check.
REQ-025 Sub-module sevseg_decoder (4-bit nibble -> 7-bit active-low segments, combinational) SHALL be instantiated once.

Verification (SCAN_DIV_W=4, BLINK_W=1 unless stated)
REQ-026 Reset then no writes -> o_an=8'hFF for 1000 clocks, o_dp=1.
REQ-027 Write ENABLE=8'hFF, DIGITS_LO=32'h76543210, BRIGHT=15 -> o_an cycles FE,FD,...,7F, 16 clocks each; o_seg matches glyph of 0..7; ack one clock after stb, single cycle.
REQ-028 N_DIGITS=5, ENABLE=5'h1F -> index sequence 0,1,2,3,4,0; o_an never 5'h1F once scanning, digit 4 followed by digit 0.
REQ-029 BRIGHT=3 -> each digit anode low 4 of 16 slot clocks; BRIGHT=0 -> 1 of 16.
REQ-030 With VEERWOLF_SEVSEG_BLINK_EN, BLINK=8'h01 -> digit 0 anode blanked on alternating 2-frame periods, others unaffected; without macro, read 0x14 after writing 8'hFF returns 0.
REQ-031 Write DP=8'h04 with i_wb_sel=4'b0001, then read 0x0C -> 32'h00000004; o_dp=0 only during digit-2 slot; i_rst mid-scan -> all outputs return to REQ-021 values next clock.

Source files
------------

// File: rtl/veerwolf_sevseg_pkg.sv
// rtl/veerwolf_sevseg_pkg.sv - register offsets, glyph table and parameter checks for the seven-segment scanner
package veerwolf_sevseg_pkg;

   localparam logic [4:0] ADR_ENABLE    = 5'h00;
   localparam logic [4:0] ADR_DIGITS_LO = 5'h04;
   localparam logic [4:0] ADR_DIGITS_HI = 5'h08;
   localparam logic [4:0] ADR_DP        = 5'h0C;
   localparam logic [4:0] ADR_BRIGHT    = 5'h10;
   localparam logic [4:0] ADR_BLINK     = 5'h14;

   // Active-low {a,b,c,d,e,f,g}, segment a in bit 6; entry 15 first.
   localparam logic [15:0][6:0] SEG_GLYPHS = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   function automatic bit n_digits_legal(input int n);
      return (n >= 1) && (n <= 16);
   endfunction

   // Byte-lane write merge; mask clears bits that do not exist in the register.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] dat,
                                               input logic [3:0] sel, input logic [31:0] mask);
      logic [31:0] lane;
      for (int b = 0; b < 4; b++) lane[8*b +: 8] = {8{sel[b]}};
      return (cur & ~(lane & mask)) | (dat & lane & mask);
   endfunction

endpackage

// File: rtl/veerwolf_sevseg_decoder.sv
// rtl/veerwolf_sevseg_decoder.sv - combinational hex nibble to active-low seven-segment decoder
module sevseg_decoder
   import veerwolf_sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_GLYPHS[nibble];

endmodule

// File: rtl/veerwolf_sevseg.sv
// rtl/veerwolf_sevseg.sv - Wishbone multiplexed seven-segment scanner; blink feature under VEERWOLF_SEVSEG_BLINK_EN
module veerwolf_sevseg
   import veerwolf_sevseg_pkg::*;
#(
   parameter int N_DIGITS   = 8,
   parameter int SCAN_DIV_W = 18,
   parameter int BLINK_W    = 6
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [4:0]          i_wb_adr,
   input  logic [31:0]         i_wb_dat,
   input  logic [3:0]          i_wb_sel,
   input  logic                i_wb_we,
   input  logic                i_wb_cyc,
   input  logic                i_wb_stb,
   output logic [31:0]         o_wb_rdt,
   output logic                o_wb_ack,
   output logic [N_DIGITS-1:0] o_an,
   output logic [6:0]          o_seg,
   output logic                o_dp
);

   localparam int               IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [31:0]      DIG_MASK = 32'((64'd1 << N_DIGITS) - 64'd1);
   localparam logic [31:0]      HI_MASK  = (N_DIGITS > 8) ? 32'hFFFF_FFFF : 32'h0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   if (!n_digits_legal(N_DIGITS) || (SCAN_DIV_W < 4)) begin : g_param_check
      $error("veerwolf_sevseg: illegal N_DIGITS or SCAN_DIV_W");
   end

   logic [31:0] enable_r, digits_lo_r, digits_hi_r, dp_r, bright_r, blink_r;
   logic [31:0] rd_data;
   logic [4:0]  reg_off;
   logic        bus_req;
   logic        unused_adr;

   assign reg_off    = {i_wb_adr[4:2], 2'b00};
   assign bus_req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
   assign unused_adr = ^i_wb_adr[1:0];

   always_comb begin
      rd_data = 32'h0;
      case (reg_off)
         ADR_ENABLE:    rd_data = enable_r;
         ADR_DIGITS_LO: rd_data = digits_lo_r;
         ADR_DIGITS_HI: rd_data = digits_hi_r;
         ADR_DP:        rd_data = dp_r;
         ADR_BRIGHT:    rd_data = bright_r;
         ADR_BLINK:     rd_data = blink_r;
         default:       rd_data = 32'h0;
      endcase
   end

   // Ack rises one clock after the request and is never held for two clocks.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_ack    <= 1'b0;
         o_wb_rdt    <= 32'h0;
         enable_r    <= 32'h0;
         digits_lo_r <= 32'h0;
         digits_hi_r <= 32'h0;
         dp_r        <= 32'h0;
         bright_r    <= 32'h0;
      end else begin
         o_wb_ack <= bus_req;
         o_wb_rdt <= bus_req ? rd_data : 32'h0;
         if (bus_req && i_wb_we) begin
            case (reg_off)
               ADR_ENABLE:    enable_r    <= merge_bytes(enable_r, i_wb_dat, i_wb_sel, DIG_MASK);
               ADR_DIGITS_LO: digits_lo_r <= merge_bytes(digits_lo_r, i_wb_dat, i_wb_sel, 32'hFFFF_FFFF);
               ADR_DIGITS_HI: digits_hi_r <= merge_bytes(digits_hi_r, i_wb_dat, i_wb_sel, HI_MASK);
               ADR_DP:        dp_r        <= merge_bytes(dp_r, i_wb_dat, i_wb_sel, DIG_MASK);
               ADR_BRIGHT:    bright_r    <= merge_bytes(bright_r, i_wb_dat, i_wb_sel, 32'h0000_000F);
               default:       ;
            endcase
         end
      end
   end

   logic [SCAN_DIV_W-1:0] presc;
   logic [IDX_W-1:0]      idx;
   logic [3:0]            idx4;
   logic                  slot_end, frame_end;

   assign idx4      = 4'(idx);
   assign slot_end  = &presc;
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
      end
   end

   logic blink_gate;

`ifdef VEERWOLF_SEVSEG_BLINK_EN
   logic [BLINK_W-1:0] frame_cnt;
   logic               blink_phase;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         blink_r     <= 32'h0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (bus_req && i_wb_we && (reg_off == ADR_BLINK))
            blink_r <= merge_bytes(blink_r, i_wb_dat, i_wb_sel, DIG_MASK);
         if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (&frame_cnt) blink_phase <= ~blink_phase;
         end
      end
   end

   assign blink_gate = blink_r[idx4] & blink_phase;
`else
   assign blink_r    = 32'h0;
   assign blink_gate = 1'b0;
`endif

   logic [63:0]         digits_all;
   logic [3:0]          nibble;
   logic [6:0]          seg_next;
   logic [N_DIGITS-1:0] an_next;
   logic                digit_on;

   assign digits_all = {digits_hi_r, digits_lo_r};
   assign nibble     = digits_all[{idx4, 2'b00} +: 4];
   assign digit_on   = enable_r[idx4] && (presc[SCAN_DIV_W-1 -: 4] <= bright_r[3:0]) && !blink_gate;

   always_comb begin
      an_next = '1;
      if (digit_on) an_next[idx] = 1'b0;
   end

   sevseg_decoder u_decoder (
      .nibble (nibble),
      .seg    (seg_next)
   );

   // All pins update on one edge so segments never ghost onto the neighbouring digit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_an  <= '1;
         o_seg <= 7'b0000001;
         o_dp  <= 1'b1;
      end else begin
         o_an  <= an_next;
         o_seg <= seg_next;
         o_dp  <= ~dp_r[idx4];
      end
   end

endmodule
